// File: rtl/stopwatch_core.sv
// -----------------------------------------------------------------------------
// stopwatch_core
// Time-keeping stage behind the 1 Hz divider. Turns each active edge of the
// divided square wave into a one-cycle tick and runs a BCD mm:ss counter
// (00:00 .. 59:59) under an IDLE / RUN / PAUSE start-stop-clear controller.
//
// Parameters:
//   TICK_POS_EDGE  1: count on rising edge of tick_in, 0: on falling edge
//   WRAP_STOP      0: 59:59 wraps to 00:00 and keeps running
//                  1: 59:59 is held and the controller drops to PAUSE
//
// Optional feature macro: STOPWATCH_LAP_EN
//   When defined, adds the lap input and a display-hold (lap freeze) register.
//
// Ports:
//   Clk         system clock; every input is synchronous to it
//   rst         synchronous, active-high reset
//   tick_in     divided 1 Hz level (square wave, same clock domain)
//   start_stop  one-cycle pulse, toggles run / pause
//   clear       one-cycle pulse, zero the count and go idle
//   lap         (STOPWATCH_LAP_EN only) one-cycle pulse, toggles display freeze
//   sec_lo      seconds units BCD (0-9)
//   sec_hi      seconds tens BCD (0-5)
//   min_lo      minutes units BCD (0-9)
//   min_hi      minutes tens BCD (0-5)
//   running     high while in RUN
//   wrap        one-cycle pulse on the 59:59 terminal tick
// -----------------------------------------------------------------------------
module stopwatch_core #(
    parameter bit TICK_POS_EDGE = 1'b1,
    parameter bit WRAP_STOP     = 1'b0
) (
    input  logic       Clk,
    input  logic       rst,
    input  logic       tick_in,
    input  logic       start_stop,
    input  logic       clear,
`ifdef STOPWATCH_LAP_EN
    input  logic       lap,
`endif
    output logic [3:0] sec_lo,
    output logic [3:0] sec_hi,
    output logic [3:0] min_lo,
    output logic [3:0] min_hi,
    output logic       running,
    output logic       wrap
);

    localparam int unsigned DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] UNIT_MAX = DIGIT_W'(9);
    localparam logic [DIGIT_W-1:0] TENS_MAX = DIGIT_W'(5);
    localparam logic [DIGIT_W-1:0] ONE      = DIGIT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t             state;
    logic               tick_prev;
    logic               tick;

    // Live count registers
    logic [DIGIT_W-1:0] cnt_sec_lo;
    logic [DIGIT_W-1:0] cnt_sec_hi;
    logic [DIGIT_W-1:0] cnt_min_lo;
    logic [DIGIT_W-1:0] cnt_min_hi;

    // Count value after one increment
    logic [DIGIT_W-1:0] inc_sec_lo;
    logic [DIGIT_W-1:0] inc_sec_hi;
    logic [DIGIT_W-1:0] inc_min_lo;
    logic [DIGIT_W-1:0] inc_min_hi;

    logic               sec_lo_max;
    logic               sec_hi_max;
    logic               min_lo_max;
    logic               min_hi_max;
    logic               terminal;
    logic               hold_at_terminal;

    // Edge detect on the divided clock, treated purely as data
    always_comb begin
        if (TICK_POS_EDGE) begin
            tick = tick_in & ~tick_prev;
        end else begin
            tick = ~tick_in & tick_prev;
        end
    end

    // BCD increment chain; ">=" keeps any out-of-range digit from propagating
    always_comb begin
        sec_lo_max = (cnt_sec_lo >= UNIT_MAX);
        sec_hi_max = (cnt_sec_hi >= TENS_MAX);
        min_lo_max = (cnt_min_lo >= UNIT_MAX);
        min_hi_max = (cnt_min_hi >= TENS_MAX);
        terminal   = sec_lo_max & sec_hi_max & min_lo_max & min_hi_max;

        inc_sec_lo = cnt_sec_lo;
        inc_sec_hi = cnt_sec_hi;
        inc_min_lo = cnt_min_lo;
        inc_min_hi = cnt_min_hi;

        if (!sec_lo_max) begin
            inc_sec_lo = cnt_sec_lo + ONE;
        end else begin
            inc_sec_lo = '0;
            if (!sec_hi_max) begin
                inc_sec_hi = cnt_sec_hi + ONE;
            end else begin
                inc_sec_hi = '0;
                if (!min_lo_max) begin
                    inc_min_lo = cnt_min_lo + ONE;
                end else begin
                    inc_min_lo = '0;
                    inc_min_hi = min_hi_max ? '0 : (cnt_min_hi + ONE);
                end
            end
        end
    end

    // At terminal count with WRAP_STOP the digits stay at 59:59
    assign hold_at_terminal = terminal & WRAP_STOP;

    // Controller, counter and status outputs; priority clear > start_stop > tick
    always_ff @(posedge Clk) begin
        if (rst) begin
            state      <= IDLE;
            running    <= 1'b0;
            wrap       <= 1'b0;
            tick_prev  <= TICK_POS_EDGE;
            cnt_sec_lo <= '0;
            cnt_sec_hi <= '0;
            cnt_min_lo <= '0;
            cnt_min_hi <= '0;
        end else begin
            tick_prev <= tick_in;
            wrap      <= 1'b0;

            if (clear) begin
                state      <= IDLE;
                running    <= 1'b0;
                cnt_sec_lo <= '0;
                cnt_sec_hi <= '0;
                cnt_min_lo <= '0;
                cnt_min_hi <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_stop) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end

                    RUN: begin
                        // A tick coinciding with start_stop is still counted
                        if (tick) begin
                            if (!hold_at_terminal) begin
                                cnt_sec_lo <= inc_sec_lo;
                                cnt_sec_hi <= inc_sec_hi;
                                cnt_min_lo <= inc_min_lo;
                                cnt_min_hi <= inc_min_hi;
                            end
                            if (terminal) begin
                                wrap <= 1'b1;
                            end
                            if (hold_at_terminal) begin
                                state   <= PAUSE;
                                running <= 1'b0;
                            end
                        end
                        if (start_stop) begin
                            state   <= PAUSE;
                            running <= 1'b0;
                        end
                    end

                    PAUSE: begin
                        if (start_stop) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end

                    default: begin
                        state   <= IDLE;
                        running <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic               freeze;
    logic [DIGIT_W-1:0] hold_sec_lo;
    logic [DIGIT_W-1:0] hold_sec_hi;
    logic [DIGIT_W-1:0] hold_min_lo;
    logic [DIGIT_W-1:0] hold_min_hi;

    // Lap freeze: capture the live count when freezing, release on the next lap
    always_ff @(posedge Clk) begin
        if (rst) begin
            freeze      <= 1'b0;
            hold_sec_lo <= '0;
            hold_sec_hi <= '0;
            hold_min_lo <= '0;
            hold_min_hi <= '0;
        end else if (clear) begin
            freeze <= 1'b0;
        end else if (lap && (state == RUN)) begin
            freeze <= ~freeze;
            if (!freeze) begin
                hold_sec_lo <= cnt_sec_lo;
                hold_sec_hi <= cnt_sec_hi;
                hold_min_lo <= cnt_min_lo;
                hold_min_hi <= cnt_min_hi;
            end
        end
    end

    // Display selects between two register banks; no input reaches it directly
    assign sec_lo = freeze ? hold_sec_lo : cnt_sec_lo;
    assign sec_hi = freeze ? hold_sec_hi : cnt_sec_hi;
    assign min_lo = freeze ? hold_min_lo : cnt_min_lo;
    assign min_hi = freeze ? hold_min_hi : cnt_min_hi;
`else
    assign sec_lo = cnt_sec_lo;
    assign sec_hi = cnt_sec_hi;
    assign min_lo = cnt_min_lo;
    assign min_hi = cnt_min_hi;
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_core
// Drives three stopwatch_core instances with the same directed stimulus:
//   dut0: rising-edge tick, wrap-around   dut1: rising-edge tick, wrap-stop
//   dut2: falling-edge tick, wrap-around
// A seconds-level model predicts every output each cycle; literal checks pin
// the model at the interesting points.
// -----------------------------------------------------------------------------
module tb_stopwatch_core;

    localparam int N = 3;
    localparam bit POS [N] = '{1'b1, 1'b1, 1'b0};
    localparam bit WS  [N] = '{1'b0, 1'b1, 1'b0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic tick_in;
    logic start_stop;
    logic clear;
`ifdef STOPWATCH_LAP_EN
    logic lap;
`endif

    logic [3:0] sl [N];
    logic [3:0] sh [N];
    logic [3:0] ml [N];
    logic [3:0] mh [N];
    logic       run_o  [N];
    logic       wrap_o [N];

    stopwatch_core #(.TICK_POS_EDGE(1'b1), .WRAP_STOP(1'b0)) dut0 (
        .Clk(clk), .rst(rst), .tick_in(tick_in), .start_stop(start_stop), .clear(clear),
`ifdef STOPWATCH_LAP_EN
        .lap(lap),
`endif
        .sec_lo(sl[0]), .sec_hi(sh[0]), .min_lo(ml[0]), .min_hi(mh[0]),
        .running(run_o[0]), .wrap(wrap_o[0])
    );

    stopwatch_core #(.TICK_POS_EDGE(1'b1), .WRAP_STOP(1'b1)) dut1 (
        .Clk(clk), .rst(rst), .tick_in(tick_in), .start_stop(start_stop), .clear(clear),
`ifdef STOPWATCH_LAP_EN
        .lap(lap),
`endif
        .sec_lo(sl[1]), .sec_hi(sh[1]), .min_lo(ml[1]), .min_hi(mh[1]),
        .running(run_o[1]), .wrap(wrap_o[1])
    );

    stopwatch_core #(.TICK_POS_EDGE(1'b0), .WRAP_STOP(1'b0)) dut2 (
        .Clk(clk), .rst(rst), .tick_in(tick_in), .start_stop(start_stop), .clear(clear),
`ifdef STOPWATCH_LAP_EN
        .lap(lap),
`endif
        .sec_lo(sl[2]), .sec_hi(sh[2]), .min_lo(ml[2]), .min_hi(mh[2]),
        .running(run_o[2]), .wrap(wrap_o[2])
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model: elapsed seconds as a plain integer plus a mode (0 idle, 1 run, 2 pause)
    int m_secs [N];
    int m_hold [N];
    int m_mode [N];
    bit m_frz  [N];
    bit m_prev [N];
    bit m_wrap [N];

    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            bit tk;
            tk = POS[k] ? (tick_in && !m_prev[k]) : (!tick_in && m_prev[k]);
            m_wrap[k] = 1'b0;
            if (rst) begin
                m_secs[k] = 0;
                m_mode[k] = 0;
                m_frz[k]  = 1'b0;
                m_hold[k] = 0;
                m_prev[k] = POS[k];
            end else begin
                if (clear) begin
                    m_secs[k] = 0;
                    m_mode[k] = 0;
                    m_frz[k]  = 1'b0;
                end else begin
`ifdef STOPWATCH_LAP_EN
                    if (lap && m_mode[k] == 1) begin
                        if (!m_frz[k]) m_hold[k] = m_secs[k];
                        m_frz[k] = !m_frz[k];
                    end
`endif
                    if (m_mode[k] == 1) begin
                        if (tk) begin
                            if (m_secs[k] == 3599) begin
                                m_wrap[k] = 1'b1;
                                if (WS[k]) m_mode[k] = 2;
                                else       m_secs[k] = 0;
                            end else begin
                                m_secs[k] = m_secs[k] + 1;
                            end
                        end
                        if (start_stop) m_mode[k] = 2;
                    end else if (start_stop) begin
                        m_mode[k] = 1;
                    end
                end
                m_prev[k] = tick_in;
            end
        end
    end

    task automatic check(input string name, input int k, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d got %0d expected %0d at %0t", name, k, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < N; k++) begin
                int s;
                s = m_frz[k] ? m_hold[k] : m_secs[k];
                check("sec_lo",  k, int'(sl[k]), (s % 60) % 10);
                check("sec_hi",  k, int'(sh[k]), (s % 60) / 10);
                check("min_lo",  k, int'(ml[k]), (s / 60) % 10);
                check("min_hi",  k, int'(mh[k]), (s / 60) / 10);
                check("running", k, int'(run_o[k]), (m_mode[k] == 1) ? 1 : 0);
                check("wrap",    k, int'(wrap_o[k]), int'(m_wrap[k]));
            end
        end
    end

    // Literal expectations for display time
    task automatic expect_time(input string name, input int k, input int mm, input int ss);
        check({name, ".sec_lo"}, k, int'(sl[k]), ss % 10);
        check({name, ".sec_hi"}, k, int'(sh[k]), ss / 10);
        check({name, ".min_lo"}, k, int'(ml[k]), mm % 10);
        check({name, ".min_hi"}, k, int'(mh[k]), mm / 10);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            tick_in = 1'b1;
            @(negedge clk);
            tick_in = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic pulse_ss();
        start_stop = 1'b1;
        @(negedge clk);
        start_stop = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        tick_in    = 1'b1;
        start_stop = 1'b0;
        clear      = 1'b0;
`ifdef STOPWATCH_LAP_EN
        lap        = 1'b0;
`endif
        @(negedge clk);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        // tick_in held high through reset release: no increment, idle
        for (int k = 0; k < N; k++) begin
            expect_time("reset", k, 0, 0);
            check("reset.running", k, int'(run_o[k]), 0);
        end
        tick_in = 1'b0;
        @(negedge clk);

        // Start and check one-cycle latency from tick_in rise to sec_lo
        pulse_ss();
        tick_in = 1'b1;
        check("lat.before", 0, int'(sl[0]), 0);
        @(negedge clk);
        check("lat.after", 0, int'(sl[0]), 1);
        tick_in = 1'b0;
        @(negedge clk);
        tick(4);
        expect_time("five", 0, 0, 5);
        check("five.running", 0, int'(run_o[0]), 1);

        tick(54);
        expect_time("t59", 0, 0, 59);
        tick(1);
        expect_time("t60", 0, 1, 0);
        tick(3539);
        expect_time("term0", 0, 59, 59);
        expect_time("term1", 1, 59, 59);

        // Terminal tick: dut0 wraps, dut1 saturates and pauses
        tick_in = 1'b1;
        @(negedge clk);
        expect_time("wrap0", 0, 0, 0);
        check("wrap0.pulse", 0, int'(wrap_o[0]), 1);
        check("wrap0.running", 0, int'(run_o[0]), 1);
        expect_time("sat1", 1, 59, 59);
        check("sat1.pulse", 1, int'(wrap_o[1]), 1);
        check("sat1.running", 1, int'(run_o[1]), 0);
        tick_in = 1'b0;
        @(negedge clk);
        check("wrap0.single", 0, int'(wrap_o[0]), 0);
        check("sat1.single", 1, int'(wrap_o[1]), 0);

        // Resume dut1 at saturation: next tick pulses wrap again, count held
        pulse_ss();
        tick_in = 1'b1;
        @(negedge clk);
        check("resat1.pulse", 1, int'(wrap_o[1]), 1);
        expect_time("resat1", 1, 59, 59);
        tick_in = 1'b0;
        @(negedge clk);
        pulse_clear();
        expect_time("clr", 1, 0, 0);

        // start_stop together with a tick while running
        pulse_ss();
        tick(7);
        expect_time("t7", 0, 0, 7);
        tick_in    = 1'b1;
        start_stop = 1'b1;
        @(negedge clk);
        start_stop = 1'b0;
        expect_time("ss_tick", 0, 0, 8);
        check("ss_tick.running", 0, int'(run_o[0]), 0);
        tick_in = 1'b0;
        @(negedge clk);
        tick(3);
        expect_time("paused", 0, 0, 8);
        pulse_clear();
        expect_time("clr2", 0, 0, 0);
        check("clr2.running", 0, int'(run_o[0]), 0);

        // clear together with a tick while running
        pulse_ss();
        tick(3);
        tick_in = 1'b1;
        clear   = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        expect_time("clr_tick", 0, 0, 0);
        check("clr_tick.wrap", 0, int'(wrap_o[0]), 0);
        tick_in = 1'b0;
        @(negedge clk);

        // start_stop with a tick in IDLE: tick ignored, enter RUN
        tick_in    = 1'b1;
        start_stop = 1'b1;
        @(negedge clk);
        start_stop = 1'b0;
        expect_time("idle_ss", 0, 0, 0);
        check("idle_ss.running", 0, int'(run_o[0]), 1);
        tick_in = 1'b0;
        @(negedge clk);
        tick(2);
        expect_time("t2", 0, 0, 2);

        // clear wins over start_stop
        clear      = 1'b1;
        start_stop = 1'b1;
        @(negedge clk);
        clear      = 1'b0;
        start_stop = 1'b0;
        check("clr_ss.running", 0, int'(run_o[0]), 0);
        expect_time("clr_ss", 0, 0, 0);

`ifdef STOPWATCH_LAP_EN
        pulse_ss();
        tick(10);
        lap = 1'b1;
        @(negedge clk);
        lap = 1'b0;
        tick(4);
        expect_time("lap.frozen", 0, 0, 10);
        lap = 1'b1;
        @(negedge clk);
        lap = 1'b0;
        expect_time("lap.live", 0, 0, 14);
        pulse_clear();
`endif

        repeat (2) @(negedge clk);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
